// File: rtl/proc_clk_ctrl.sv
// Processor clock controller.
// Turns the clock divider's slow square wave into single-cycle ticks and
// debounces the manual step key. A HALTED/RUN/STEP machine then issues one
// cpuEn pulse per executed instruction cycle.
// cpuEn contract: a registered, one-cycle enable. The processor advances in
// exactly those clkIn cycles where cpuEn is high. There is no back-pressure.
module proc_clk_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic        clkIn,
  input  logic        rst,
  input  logic        slowClk,
  input  logic        stepKey,
  input  logic        runSw,
  input  logic        haltReq,
  output logic        cpuEn,
  output logic        running,
  output logic [1:0]  fsmState,
  output logic [15:0] stepCount
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Bit 0 is the first synchronizer flop. Bit 2 of slow_sh is the edge-detect flop.
  logic [2:0]      slow_sh_q, slow_sh_d;
  logic [1:0]      key_sh_q, key_sh_d;
  logic [1:0]      run_sh_q, run_sh_d;
  logic            key_stable_q, key_stable_d;
  logic            key_prev_q, key_prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  state_e          state_q, state_d;
  logic            cpu_en_q, cpu_en_d;
  logic [15:0]     step_count_q, step_count_d;
  logic            run_arm_q, run_arm_d;

  logic tick;
  logic press;
  logic key_sync;
  logic run_sync;

  assign tick     = slow_sh_q[1] & ~slow_sh_q[2];
  assign key_sync = key_sh_q[1];
  assign run_sync = run_sh_q[1];
  // The key is active-low, so a press is a 1->0 move of the debounced level.
  assign press    = key_prev_q & ~key_stable_q;

  // Next values for the synchronizers and the key debouncer.
  always_comb begin
    slow_sh_d    = {slow_sh_q[1:0], slowClk};
    key_sh_d     = {key_sh_q[0], stepKey};
    run_sh_d     = {run_sh_q[0], runSw};
    key_prev_d   = key_stable_q;
    key_stable_d = key_stable_q;
    db_cnt_d     = '0;
    if (key_sync != key_stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_stable_d = key_sync;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Register the synchronizers and the debouncer. The key path resets to "released".
  always_ff @(posedge clkIn) begin
    if (rst) begin
      slow_sh_q    <= '0;
      key_sh_q     <= '1;
      run_sh_q     <= '0;
      key_stable_q <= 1'b1;
      key_prev_q   <= 1'b1;
      db_cnt_q     <= '0;
    end else begin
      slow_sh_q    <= slow_sh_d;
      key_sh_q     <= key_sh_d;
      run_sh_q     <= run_sh_d;
      key_stable_q <= key_stable_d;
      key_prev_q   <= key_prev_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  // Run/step/halt decisions. A halt beats a tick in the same cycle.
  // A HALT instruction disarms run until runSw is seen low again.
  always_comb begin
    state_d   = state_q;
    cpu_en_d  = 1'b0;
    run_arm_d = run_arm_q | ~run_sync;
    case (state_q)
      ST_HALTED: begin
        if (run_sync && run_arm_q) begin
          state_d = ST_RUN;
        end else if (press) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (haltReq) begin
          state_d   = ST_HALTED;
          run_arm_d = 1'b0;
        end else if (!run_sync) begin
          state_d = ST_HALTED;
        end else if (tick) begin
          cpu_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (tick) begin
          cpu_en_d = 1'b1;
          state_d  = ST_HALTED;
        end
      end
      default: state_d = ST_HALTED;
    endcase
    step_count_d = step_count_q + {15'd0, cpu_en_d};
  end

  // FSM state, the registered enable and the pulse counter.
  always_ff @(posedge clkIn) begin
    if (rst) begin
      state_q      <= ST_HALTED;
      cpu_en_q     <= 1'b0;
      step_count_q <= '0;
      run_arm_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cpu_en_q     <= cpu_en_d;
      step_count_q <= step_count_d;
      run_arm_q    <= run_arm_d;
    end
  end

  assign cpuEn     = cpu_en_q;
  assign stepCount = step_count_q;
  assign running   = (state_q == ST_RUN);
  assign fsmState  = state_q;

endmodule

// File: tb/tb_proc_clk_ctrl.sv
// Directed bench for proc_clk_ctrl with a 4-cycle debounce and a
// 16-cycle slowClk period. Inputs are driven and outputs are sampled on
// the falling edge of clkIn.
module tb_proc_clk_ctrl;

  logic        clkIn = 1'b0;
  logic        rst = 1'b1;
  logic        slowClk = 1'b0;
  logic        stepKey = 1'b1;
  logic        runSw = 1'b0;
  logic        haltReq = 1'b0;
  logic        cpuEn;
  logic        running;
  logic [1:0]  fsmState;
  logic [15:0] stepCount;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int last_rise = -100;
  int slow_ph = 14;
  bit slow_en = 1'b1;
  logic [15:0] exp_q[$];

  proc_clk_ctrl #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clkIn(clkIn), .rst(rst), .slowClk(slowClk), .stepKey(stepKey),
    .runSw(runSw), .haltReq(haltReq), .cpuEn(cpuEn), .running(running),
    .fsmState(fsmState), .stepCount(stepCount)
  );

  // Clock / watchdog
  always #5 clkIn = ~clkIn;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clkIn cycle. slowClk has a 16-cycle period and rises when the phase wraps to 0.
  task automatic cyc();
    @(negedge clkIn);
    cyc_n++;
    if (slow_en) begin
      slow_ph = (slow_ph + 1) % 16;
      if (slow_ph == 0) last_rise = cyc_n;
      slowClk = (slow_ph < 8);
    end else begin
      slowClk = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    int pulses;
    int entries;
    int first_rise;
    logic prev_en;
    logic [1:0] prev_state;
    bit ok;

    // Reset held 3 edges while slowClk toggles
    repeat (3) begin
      cyc();
      chk("rst_en", 32'(cpuEn), 32'd0);
      chk("rst_state", 32'(fsmState), 32'd0);
      chk("rst_cnt", 32'(stepCount), 32'd0);
    end
    rst = 1'b0;
    cyc();
    chk("rel_en", 32'(cpuEn), 32'd0);
    chk("rel_state", 32'(fsmState), 32'd0);
    chk("rel_cnt", 32'(stepCount), 32'd0);
    chk("rel_running", 32'(running), 32'd0);

    // Free run: RUN three edges after runSw is driven, then 10 periods
    slow_en = 1'b0;
    runSw = 1'b1;
    cyc();
    cyc();
    chk("run_entry_early", 32'(fsmState), 32'd0);
    cyc();
    chk("run_entry", 32'(fsmState), 32'd1);
    chk("run_running", 32'(running), 32'd1);
    slow_ph = 15;
    slow_en = 1'b1;
    pulses = 0;
    prev_en = 1'b0;
    repeat (160) begin
      cyc();
      chk("run_en", 32'(cpuEn), 32'(cyc_n == last_rise + 3));
      chk("run_b2b", 32'(cpuEn & prev_en), 32'd0);
      if (cpuEn) pulses++;
      prev_en = cpuEn;
    end
    slow_en = 1'b0;
    chk("run_pulses", 32'(pulses), 32'd10);
    chk("run_cnt", 32'(stepCount), 32'd10);
    chk("run_state", 32'(fsmState), 32'd1);

    // HALT instruction coinciding with a tick
    slow_ph = 15;
    slow_en = 1'b1;
    cyc();
    cyc();
    cyc();
    haltReq = 1'b1;
    cyc();
    haltReq = 1'b0;
    chk("halt_en", 32'(cpuEn), 32'd0);
    chk("halt_state", 32'(fsmState), 32'd0);
    chk("halt_cnt", 32'(stepCount), 32'd10);
    repeat (20) begin
      cyc();
      chk("halt_stay", 32'(fsmState), 32'd0);
      chk("halt_no_en", 32'(cpuEn), 32'd0);
    end
    slow_en = 1'b0;
    runSw = 1'b0;
    repeat (4) cyc();
    chk("rearm_state", 32'(fsmState), 32'd0);
    runSw = 1'b1;
    cyc();
    cyc();
    chk("resume_early", 32'(fsmState), 32'd0);
    cyc();
    chk("resume", 32'(fsmState), 32'd1);
    runSw = 1'b0;
    repeat (4) cyc();
    chk("stop_state", 32'(fsmState), 32'd0);

    // Bounce, then a held press, then one step
    apply_reset();
    chk("t4_cnt0", 32'(stepCount), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc();
      stepKey = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      chk("bounce_state", 32'(fsmState), 32'd0);
    end
    cyc();
    stepKey = 1'b0;
    prev_state = fsmState;
    entries = 0;
    for (int j = 1; j <= 40; j++) begin
      cyc();
      if (j == 6) chk("step_early", 32'(fsmState), 32'd0);
      if (j == 7) chk("step_entry", 32'(fsmState), 32'd2);
      if (fsmState == 2'd2 && prev_state != 2'd2) entries++;
      prev_state = fsmState;
    end
    stepKey = 1'b1;
    chk("step_entries", 32'(entries), 32'd1);
    repeat (8) cyc();
    chk("step_hold", 32'(fsmState), 32'd2);
    chk("step_no_en", 32'(cpuEn), 32'd0);
    slow_ph = 15;
    slow_en = 1'b1;
    cyc();
    first_rise = last_rise;
    for (int k = 2; k <= 24; k++) begin
      cyc();
      chk("step_en", 32'(cpuEn), 32'(cyc_n == first_rise + 3));
      if (k == 3) chk("step_wait", 32'(fsmState), 32'd2);
      if (k == 4) chk("step_done", 32'(fsmState), 32'd0);
    end
    slow_en = 1'b0;
    chk("step_cnt", 32'(stepCount), 32'd1);

    // Counter wrap from 16'hFFFE
    cyc();
    force dut.step_count_q = 16'hFFFE;
    cyc();
    release dut.step_count_q;
    chk("wrap_preload", 32'(stepCount), 32'h0000FFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    runSw = 1'b1;
    repeat (3) cyc();
    chk("wrap_run", 32'(fsmState), 32'd1);
    slow_ph = 15;
    slow_en = 1'b1;
    repeat (40) begin
      cyc();
      if (cpuEn) begin
        if (exp_q.size() == 0) begin
          chk("wrap_extra", 32'(cpuEn), 32'd0);
        end else begin
          chk("wrap_cnt", 32'(stepCount), 32'(exp_q.pop_front()));
        end
      end
    end
    chk("wrap_left", 32'(exp_q.size()), 32'd0);
    slow_en = 1'b0;
    runSw = 1'b0;
    repeat (4) cyc();
    chk("wrap_stop", 32'(fsmState), 32'd0);

    // Reset while in STEP, just before the tick
    stepKey = 1'b0;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      cyc();
      if (fsmState == 2'd2) ok = 1'b1;
    end
    chk("mid_step_reach", 32'(ok), 32'd1);
    stepKey = 1'b1;
    repeat (10) cyc();
    chk("mid_step_hold", 32'(fsmState), 32'd2);
    chk("mid_pre_cnt", 32'(stepCount), 32'd1);
    slow_ph = 15;
    slow_en = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("mid_rst_en", 32'(cpuEn), 32'd0);
    chk("mid_rst_state", 32'(fsmState), 32'd0);
    chk("mid_rst_cnt", 32'(stepCount), 32'd0);
    repeat (12) begin
      cyc();
      chk("mid_post_en", 32'(cpuEn), 32'd0);
      chk("mid_post_state", 32'(fsmState), 32'd0);
    end
    chk("mid_post_cnt", 32'(stepCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proc_clk_ctrl.md
# proc_clk_ctrl

Processor clock controller that sits directly downstream of the 4 Hz clock divider and drives the processor's clock enable. It synchronizes the divider's slow square wave into single-cycle ticks and debounces the manual step pushbutton. A run/step/halt state machine then emits exactly one `cpuEn` pulse per executed instruction cycle. The processor runs on `clkIn` and advances only in cycles where `cpuEn` is high.

## Interface
- `DB_CYCLES`, 500000, consecutive `clkIn` cycles the synchronized key must differ from its debounced value before the change is accepted (10 ms at 50 MHz).
- `DB_W`, 20, width of the debounce counter. Must satisfy 2^DB_W > DB_CYCLES.
- `clkIn`  in  1  system clock, 50 MHz board clock.
- `rst`  in  1  synchronous, active-high reset.
- `slowClk`  in  1  square wave from the clock divider. Asynchronous to this block's logic, so it is treated as async.
- `stepKey`  in  1  raw pushbutton, active-low (0 = pressed). Asynchronous and bouncy.
- `runSw`  in  1  run switch, 1 = free-run. Asynchronous.
- `haltReq`  in  1  from the processor, 1 = HALT instruction executed. Synchronous to `clkIn`.
- `cpuEn`  out  1  one-cycle clock-enable pulse to the processor.
- `running`  out  1  high while the FSM is in RUN.
- `fsmState`  out  2  current state: 0 HALTED, 1 RUN, 2 STEP.
- `stepCount`  out  16  number of `cpuEn` pulses issued since reset.

## Operation
- **Synchronizers**
  - `slowClk`, `stepKey` and `runSw` each pass through a 2-flop synchronizer.
  - `slowClk` has a third flop for edge detection.
  - `tick` = synchronized `slowClk` high AND the third flop low. This is a rising-edge detect, one cycle per divider period.
- **Debouncer**
  - Register `keyStable` resets to 1 (released).
  - If the synchronized key equals `keyStable`: counter is set to 0.
  - Otherwise the counter increments. When it equals DB_CYCLES-1, `keyStable` takes the synchronized value and the counter is set to 0.
  - `press` is a one-cycle pulse in the cycle after `keyStable` transitions 1 to 0. A held key produces exactly one `press`.
- **FSM** (states HALTED, RUN, STEP; reset state HALTED):
  - HALTED:
    - If synchronized `runSw`=1 and `runArm`=1, go to RUN.
    - Otherwise, if `press`, go to STEP.
    - RUN takes priority when both conditions are true.
  - RUN:
    - If `haltReq`=1, go to HALTED and clear `runArm`.
    - Otherwise, if synchronized `runSw`=0, go to HALTED.
    - Otherwise, if `tick`, assert `cpuEn` next cycle and stay in RUN.
    - `haltReq` and `tick` in the same cycle: the halt wins and no `cpuEn` is issued.
  - STEP:
    - On `tick`, assert `cpuEn` next cycle and go to HALTED.
    - `press` events while in STEP are ignored; they are not queued.
- **`runArm`**
  - Set to 1 on reset.
  - Cleared by a `haltReq`-induced halt.
  - Set again whenever synchronized `runSw`=0.
  - Effect: after a HALT instruction, the operator must cycle `runSw` to 0 and back to 1 to resume. Single-step remains available while disarmed.
- **`stepCount`**
  - Increments by 1 in the same edge that registers `cpuEn`=1.
  - Wraps from 16'hFFFF to 16'h0000 without a flag.
- **Outputs**
  - `cpuEn` and `stepCount` are registered.
  - `running` and `fsmState` decode directly from the state register.

## Timing
- **Reset values:** `cpuEn`=0, `running`=0, `fsmState`=0 (HALTED), `stepCount`=0, `runArm`=1, `keyStable`=1, debounce counter=0, all synchronizer flops=0 except `stepKey` synchronizer flops=1.
- **Reset mid-operation:**
  - `rst` asserted on any edge forces all of the above on that edge.
  - A pending `cpuEn` is dropped and an in-progress debounce is discarded.
- **Tick latency:**
  - Let edge E0 be the first edge that samples `slowClk` high.
  - `tick` is valid between edge E1 and edge E2.
  - `cpuEn` is high for exactly the cycle after edge E2.
  - Net: `cpuEn` follows the `slowClk` rising edge by 3 edges.
- **Rate limit:** `cpuEn` is never high in two consecutive cycles. At most one pulse is issued per `slowClk` period.
- **Debounce latency:**
  - A clean key press sampled at E0 reaches the synchronized value at E1.
  - `keyStable` falls at edge E1+DB_CYCLES.
  - `press` is high for the cycle after that edge.
- **`runSw`:** changes take effect in the FSM 2 edges after sampling (synchronizer delay). No debouncing is applied.

## Test plan
All scenarios use DB_CYCLES=4, DB_W=3, and a `slowClk` period of 16 `clkIn` cycles.
- **Reset:** hold `rst` for 3 cycles while `slowClk` toggles -> `cpuEn`=0, `fsmState`=0, `stepCount`=0 throughout and in the first cycle after release.
- **Free run:** `runSw`=1 for 10 `slowClk` periods -> `fsmState`=1 and exactly 10 one-cycle `cpuEn` pulses, each 3 edges after a `slowClk` rise; `stepCount`=10.
- **Bounce and step:** in HALTED, toggle `stepKey` 0/1 every 2 cycles for 12 cycles, then hold it at 0 for 40 cycles -> exactly one `press`, FSM goes to STEP, one `cpuEn` on the next tick, return to HALTED; `stepCount`=1.
- **HALT instruction:** in RUN, assert `haltReq` in the same cycle as `tick` -> no `cpuEn`, HALTED next cycle. With `runSw` held at 1 the FSM stays HALTED; drop `runSw` to 0, then raise it to 1 -> RUN.
- **Wrap-around:** preload `stepCount` to 16'hFFFE via the bench force/release hook and run 3 ticks -> values 16'hFFFF, 16'h0000, 16'h0001.
- **Reset mid-step:** assert `rst` while in STEP one cycle before `tick` -> no `cpuEn` is issued, HALTED, `stepCount`=0.
